// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional transfer watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [3:0] BIT_STOP = 4'd9;

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 2");
    end

    logic [2:0]       state_q, state_d;
    logic [9:0]       frame_q, frame_d;       // {stop, parity, data}
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [2:0]       c_sync_q, c_sync_d;     // [0] meta, [1] synced, [2] previous synced
    logic [1:0]       d_sync_q, d_sync_d;
    logic             ps2c_oe_q, ps2c_oe_d;
    logic             ps2d_oe_q, ps2d_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;
    logic             c_fall_c;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    assign c_fall_c = c_sync_q[2] & ~c_sync_q[1];

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        c_sync_d  = {c_sync_q[1:0], ps2c_in};
        d_sync_d  = {d_sync_q[0], ps2d_in};
        ps2c_oe_d = ps2c_oe_q;
        ps2d_oe_d = ps2d_oe_q;
        tx_done_d = 1'b0;
        tx_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = 4'd0;
                    inh_cnt_d = '0;
                    ps2c_oe_d = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + INH_W'(1);
                // Data goes low one cycle before the clock is released
                if (inh_cnt_q == INH_DATA) begin
                    ps2d_oe_d = 1'b1;
                end
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    ps2c_oe_d = 1'b0;
                    ps2d_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (c_fall_c) begin
                    bit_cnt_d = 4'd0;
                    ps2d_oe_d = ~frame_q[0];
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (c_fall_c) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    ps2d_oe_d = ~frame_q[bit_cnt_d];
                    if (bit_cnt_d == BIT_STOP) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (c_fall_c) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (!d_sync_q[1]) begin
                        state_d = ST_RELEASE;
                    end else begin
                        tx_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_RELEASE: begin
                if (c_sync_q[1] && d_sync_q[1]) begin
                    tx_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog runs from the first request cycle until the bus returns to idle
        wd_cnt_d = '0;
        if (state_q != ST_IDLE && state_q != ST_INHIBIT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if (wd_cnt_q == WD_LAST && !tx_done_d) begin
                wd_cnt_d  = '0;
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
                tx_err_d  = 1'b1;
                state_d   = ST_IDLE;
            end
        end
`endif

        tx_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            c_sync_q   <= '1;
            d_sync_q   <= '1;
            ps2c_oe_q  <= 1'b0;
            ps2d_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            c_sync_q   <= c_sync_d;
            d_sync_q   <= d_sync_d;
            ps2c_oe_q  <= ps2c_oe_d;
            ps2d_oe_q  <= ps2d_oe_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
`endif
        end
    end

    assign tx_ready = tx_ready_q;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;
    assign ps2c_oe  = ps2c_oe_q;
    assign ps2d_oe  = ps2d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device clocking frames out of the host.
module tb_ps2_host_tx;

    localparam int unsigned INHIBIT = 5000;
    localparam int unsigned TIMEOUT = 2000;
    localparam int          HALF    = 20;

    logic       clk_50mhz = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2c_oe, ps2d_oe;
    logic       dev_c, dev_d;
    logic       ps2c_in, ps2d_in;

    // Wired-AND open-drain bus between host and device
    assign ps2c_in = ~ps2c_oe & dev_c;
    assign ps2d_in = ~ps2d_oe & dev_d;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0, err_cnt = 0, pulse_bad = 0;
    int inh_run = 0, d_idx = -1, last_inh = 0, last_d_idx = -1;
    logic done_prev = 1'b0, err_prev = 1'b0;

    always #10 clk_50mhz = ~clk_50mhz;

    ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .ps2c_in   (ps2c_in),
        .ps2d_in   (ps2d_in),
        .ps2c_oe   (ps2c_oe),
        .ps2d_oe   (ps2d_oe)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected line levels, index 0 = start bit, 1..8 = data LSB first, 9 = odd parity, 10 = stop
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Pulse bookkeeping and inhibit-window measurement
    always @(negedge clk_50mhz) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if ((tx_done && tx_err) || (tx_done && done_prev) || (tx_err && err_prev)) pulse_bad++;
        done_prev = tx_done;
        err_prev  = tx_err;
        if (ps2c_oe) begin
            if (ps2d_oe && d_idx < 0) d_idx = inh_run;
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh   = inh_run;
            last_d_idx = d_idx;
            inh_run    = 0;
            d_idx      = -1;
        end
    end

    task automatic wait_req(output logic ok);
        int n = 0;
        while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && n < 6000) begin
            @(negedge clk_50mhz);
            n++;
        end
        ok = (n < 6000);
    endtask

    // Device clocks the frame; samples the line at the end of each high phase
    task automatic dev_frame(input logic ack, input int stop_after,
                             output logic [10:0] bits, output logic ok);
        bits = '0;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < 11; i++) begin
            repeat (HALF) @(negedge clk_50mhz);
            bits[i] = ps2d_in;
            if (i == stop_after) return;
            if (i == 10) begin
                dev_d = ~ack;
                repeat (4) @(negedge clk_50mhz);
            end
            dev_c = 1'b0;
            repeat (HALF) @(negedge clk_50mhz);
            dev_c = 1'b1;
        end
        repeat (4) @(negedge clk_50mhz);
        dev_d = 1'b1;
    endtask

    task automatic start_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk_50mhz);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk_50mhz);
        tx_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int limit);
        int n = 0;
        while (!(tx_done || tx_err) && n < limit) begin
            @(negedge clk_50mhz);
            n++;
        end
        @(negedge clk_50mhz);
    endtask

    task automatic run_xfer(input logic [7:0] b, input logic ack);
        int d0, e0;
        logic [10:0] bits;
        logic ok;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        dev_frame(ack, 11, bits, ok);
        check_eq("req_seen", 32'(ok), 32'd1);
        check_eq("frame_bits", 32'(bits), 32'(frame_of(b)));
        wait_pulse(200);
        check_eq("done_pulses", 32'(done_cnt - d0), {31'd0, ack});
        check_eq("err_pulses", 32'(err_cnt - e0), {31'd0, ~ack});
        check_eq("ready_after", 32'(tx_ready), 32'd1);
        check_eq("inhibit_len", 32'(last_inh), 32'(INHIBIT));
        check_eq("data_low_idx", 32'(last_d_idx), 32'(INHIBIT - 1));
    endtask

    initial begin
        repeat (150000) @(posedge clk_50mhz);
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [10:0] bits;
        logic [10:0] exp_frame;
        logic        ok;
        logic [7:0]  b1, b2;
        int          d0, e0, n;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_c    = 1'b1;
        dev_d    = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        check_eq("rst_c_oe", 32'(ps2c_oe), 32'd0);
        check_eq("rst_d_oe", 32'(ps2d_oe), 32'd0);
        check_eq("rst_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_done", 32'(tx_done), 32'd0);
        check_eq("rst_err", 32'(tx_err), 32'd0);
        reset = 1'b0;
        @(negedge clk_50mhz);
        check_eq("idle_ready", 32'(tx_ready), 32'd1);

        run_xfer(8'hED, 1'b1);
        run_xfer(8'hF4, 1'b1);
        run_xfer(8'($urandom_range(0, 255)), 1'b0);

        // Reset while d4 is on the line
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h0F);
        dev_frame(1'b1, 5, bits, ok);
        exp_frame = frame_of(8'h0F);
        check_eq("mid_req_seen", 32'(ok), 32'd1);
        check_eq("mid_partial", 32'(bits[5:0]), 32'(exp_frame[5:0]));
        check_eq("mid_d_oe_pre", 32'(ps2d_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk_50mhz);
        check_eq("mid_rst_c_oe", 32'(ps2c_oe), 32'd0);
        check_eq("mid_rst_d_oe", 32'(ps2d_oe), 32'd0);
        check_eq("mid_rst_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;
        repeat (50) @(negedge clk_50mhz);
        check_eq("mid_rst_done", 32'(done_cnt - d0), 32'd0);
        check_eq("mid_rst_err", 32'(err_cnt - e0), 32'd0);

        for (int k = 0; k < 3; k++) begin
            run_xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // tx_valid held with tx_data changed mid-transfer
        d0 = done_cnt;
        b1 = 8'($urandom_range(0, 255));
        b2 = ~b1;
        n  = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk_50mhz);
            n++;
        end
        tx_data  = b1;
        tx_valid = 1'b1;
        @(negedge clk_50mhz);
        tx_data = b2;
        dev_frame(1'b1, 11, bits, ok);
        check_eq("hold_frame1", 32'(bits), 32'(frame_of(b1)));
        n = 0;
        while (!tx_done && n < 200) begin
            @(negedge clk_50mhz);
            n++;
        end
        check_eq("hold_ready_at_done", 32'(tx_ready), 32'd1);
        @(negedge clk_50mhz);
        tx_valid = 1'b0;
        check_eq("hold_second_taken", 32'(tx_ready), 32'd0);
        dev_frame(1'b1, 11, bits, ok);
        check_eq("hold_frame2", 32'(bits), 32'(frame_of(b2)));
        wait_pulse(200);
        check_eq("hold_done_pulses", 32'(done_cnt - d0), 32'd2);

        // Device never clocks
        e0 = err_cnt;
        start_tx(8'($urandom_range(0, 255)));
        wait_req(ok);
        check_eq("stall_req_seen", 32'(ok), 32'd1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        n = 0;
        while (!tx_err && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        check_eq("wd_cycles", 32'(n), 32'(TIMEOUT));
        check_eq("wd_c_oe", 32'(ps2c_oe), 32'd0);
        check_eq("wd_d_oe", 32'(ps2d_oe), 32'd0);
        check_eq("wd_ready", 32'(tx_ready), 32'd1);
        @(negedge clk_50mhz);
        check_eq("wd_err_pulses", 32'(err_cnt - e0), 32'd1);
`else
        repeat (3000) @(negedge clk_50mhz);
        check_eq("stall_c_oe", 32'(ps2c_oe), 32'd0);
        check_eq("stall_d_oe", 32'(ps2d_oe), 32'd1);
        check_eq("stall_ready", 32'(tx_ready), 32'd0);
        check_eq("stall_err", 32'(err_cnt - e0), 32'd0);
        reset = 1'b1;
        @(negedge clk_50mhz);
        reset = 1'b0;
        @(negedge clk_50mhz);
        check_eq("stall_rst_ready", 32'(tx_ready), 32'd1);
`endif

        check_eq("pulse_rules", 32'(pulse_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
